// File: rtl/hex_palette_sequencer_if.sv
// Pixel bus between the hex coordinate generator and the palette sequencer.
// The generator (master) drives quadrant/radius and reads back the colour;
// the sequencer (slave) consumes coordinates and produces the colour.
interface hex_palette_sequencer_if;
  logic       pixel_valid;
  logic [2:0] quadrant;
  logic [9:0] radius;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       colour_valid;

  modport master (
    output pixel_valid, quadrant, radius,
    input  red, green, blue, colour_valid
  );

  modport slave (
    input  pixel_valid, quadrant, radius,
    output red, green, blue, colour_valid
  );
endinterface

// File: rtl/hex_palette_sequencer.sv
// hex_palette_sequencer: timed palette scheme for the hex renderer.
// Per frame, a HOLD/FADE FSM steps through four built-in palettes and
// cross-fades each into the next over 16 frames. Per pixel, (quadrant,
// radius) is mapped to a 12-bit colour through a 2-stage pipeline.
// Optional feature macro: HEX_PULSE_EN adds a beat-driven brightness boost
// to the A/B sectors; without it pulse_trigger is ignored.
module hex_palette_sequencer #(
  parameter int HOLD_FRAMES = 240,
  parameter int CENTRE_R    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    pulse_trigger,
  hex_palette_sequencer_if.slave  pix,
  output logic [1:0]              palette_idx,
  output logic                    fading
);

  localparam logic [9:0] HOLD_LAST  = 10'(HOLD_FRAMES - 1);
  localparam logic [9:0] CENTRE_LIM = 10'(CENTRE_R);

  typedef enum logic {HOLD, FADE} state_t;

  // Pixel class: which palette entry (or black) a coordinate maps to.
  typedef enum logic [1:0] {
    CLS_A     = 2'd0,
    CLS_B     = 2'd1,
    CLS_C     = 2'd2,
    CLS_BLACK = 2'd3
  } pix_class_t;

  state_t     state;
  logic [9:0] frame_cnt;
  logic [3:0] step;

  pix_class_t pix_class;
  logic [1:0] nxt_idx;
  logic [3:0] blend_step;
  logic [11:0] cur_col;
  logic [11:0] nxt_col;
  logic [3:0] mix_red;
  logic [3:0] mix_green;
  logic [3:0] mix_blue;

  logic       s1_valid;
  logic [3:0] s1_red;
  logic [3:0] s1_green;
  logic [3:0] s1_blue;

  // Palette ROM: A/B vary per palette, C is white everywhere, black is 000.
  function automatic logic [11:0] palette_entry(input logic [1:0] idx,
                                                input pix_class_t cls);
    logic [11:0] col;
    col = 12'h000;
    case (cls)
      CLS_A: begin
        case (idx)
          2'd0: col = 12'hF40;
          2'd1: col = 12'h0F4;
          2'd2: col = 12'h04F;
          default: col = 12'hF0F;
        endcase
      end
      CLS_B: begin
        case (idx)
          2'd0: col = 12'h810;
          2'd1: col = 12'h081;
          2'd2: col = 12'h018;
          default: col = 12'h808;
        endcase
      end
      CLS_C: col = 12'hFFF;
      default: col = 12'h000;
    endcase
    return col;
  endfunction

  // Linear blend of one 4-bit channel; the weights always sum to 16 so the
  // shifted result never exceeds 15.
  function automatic logic [3:0] blend(input logic [3:0] cur,
                                       input logic [3:0] nxt,
                                       input logic [3:0] stp);
    logic [8:0] w_nxt;
    logic [8:0] w_cur;
    logic [8:0] sum;
    w_nxt = {5'd0, stp};
    w_cur = 9'd16 - w_nxt;
    sum   = ({5'd0, cur} * w_cur) + ({5'd0, nxt} * w_nxt);
    return 4'(sum >> 4);
  endfunction

  // Palette FSM: count held frames, then step the fade, then advance palette.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HOLD;
      frame_cnt   <= 10'd0;
      step        <= 4'd0;
      palette_idx <= 2'd0;
      fading      <= 1'b0;
    end else if (frame_start) begin
      case (state)
        HOLD: begin
          if (frame_cnt == HOLD_LAST) begin
            frame_cnt <= 10'd0;
            step      <= 4'd0;
            state     <= FADE;
            fading    <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 10'd1;
          end
        end
        FADE: begin
          if (step == 4'd15) begin
            step        <= 4'd0;
            palette_idx <= palette_idx + 2'd1;
            state       <= HOLD;
            fading      <= 1'b0;
          end else begin
            step <= step + 4'd1;
          end
        end
        default: begin
          state  <= HOLD;
          fading <= 1'b0;
        end
      endcase
    end
  end

  // Classify the pixel and blend current/next palette entries.
  always_comb begin
    pix_class = CLS_A;
    if (pix.quadrant[2:1] == 2'b11) begin
      pix_class = CLS_BLACK;
    end else if (pix.radius < CENTRE_LIM) begin
      pix_class = CLS_C;
    end else if (pix.quadrant[0]) begin
      pix_class = CLS_B;
    end
    nxt_idx    = palette_idx + 2'd1;
    blend_step = (state == FADE) ? step : 4'd0;
    cur_col    = palette_entry(palette_idx, pix_class);
    nxt_col    = palette_entry(nxt_idx, pix_class);
    mix_red    = blend(cur_col[11:8], nxt_col[11:8], blend_step);
    mix_green  = blend(cur_col[7:4],  nxt_col[7:4],  blend_step);
    mix_blue   = blend(cur_col[3:0],  nxt_col[3:0],  blend_step);
  end

  // Stage 1: register the blended colour and the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_red   <= 4'd0;
      s1_green <= 4'd0;
      s1_blue  <= 4'd0;
    end else begin
      s1_valid <= pix.pixel_valid;
      s1_red   <= mix_red;
      s1_green <= mix_green;
      s1_blue  <= mix_blue;
    end
  end

`ifdef HEX_PULSE_EN
  logic [3:0] boost;
  logic       s1_boost_ok;

  // Add half the boost to a channel, clamping at full brightness.
  function automatic logic [3:0] sat_add(input logic [3:0] ch,
                                         input logic [3:0] amt);
    logic [4:0] sum;
    sum = {1'b0, ch} + {1'b0, amt};
    return sum[4] ? 4'hF : sum[3:0];
  endfunction

  // Beat boost: reload on pulse, decay by one per frame down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boost <= 4'd0;
    end else if (pulse_trigger) begin
      boost <= 4'd8;
    end else if (frame_start && (boost != 4'd0)) begin
      boost <= boost - 4'd1;
    end
  end

  // Only the coloured sectors get boosted; centre and black stay as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_boost_ok <= 1'b0;
    end else begin
      s1_boost_ok <= (pix_class == CLS_A) || (pix_class == CLS_B);
    end
  end

  // Stage 2: apply saturating boost and drive the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix.colour_valid <= 1'b0;
      pix.red          <= 4'd0;
      pix.green        <= 4'd0;
      pix.blue         <= 4'd0;
    end else begin
      pix.colour_valid <= s1_valid;
      if (s1_boost_ok) begin
        pix.red   <= sat_add(s1_red,   boost >> 1);
        pix.green <= sat_add(s1_green, boost >> 1);
        pix.blue  <= sat_add(s1_blue,  boost >> 1);
      end else begin
        pix.red   <= s1_red;
        pix.green <= s1_green;
        pix.blue  <= s1_blue;
      end
    end
  end
`else
  logic unused_pulse;
  assign unused_pulse = pulse_trigger;

  // Stage 2: plain output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix.colour_valid <= 1'b0;
      pix.red          <= 4'd0;
      pix.green        <= 4'd0;
      pix.blue         <= 4'd0;
    end else begin
      pix.colour_valid <= s1_valid;
      pix.red          <= s1_red;
      pix.green        <= s1_green;
      pix.blue         <= s1_blue;
    end
  end
`endif

endmodule

// File: tb/tb_hex_palette_sequencer.sv
// Directed testbench for hex_palette_sequencer with HOLD_FRAMES=4.
// Table of single-pixel vectors in P0 HOLD, then hand-written sequences for
// pipelining, fade timing, palette wrap, async reset and the boost option.
module tb_hex_palette_sequencer;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       pulse_trigger;
  logic [1:0] palette_idx;
  logic       fading;

  int total_checks;
  int passed_checks;

  hex_palette_sequencer_if bus ();

  hex_palette_sequencer #(
    .HOLD_FRAMES(4),
    .CENTRE_R(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .pulse_trigger(pulse_trigger),
    .pix(bus.slave),
    .palette_idx(palette_idx),
    .fading(fading)
  );

  typedef struct {
    logic        pv;
    logic [2:0]  q;
    logic [9:0]  r;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[11];

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic pv, input logic [2:0] q,
                                input logic [9:0] r);
    bus.pixel_valid = pv;
    bus.quadrant    = q;
    bus.radius      = r;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_pixel(input string name, input logic [11:0] exp_rgb,
                             input logic exp_valid);
    check_output({name, " rgb"}, {4'd0, bus.red, bus.green, bus.blue},
                 {4'd0, exp_rgb});
    check_output({name, " valid"}, {15'd0, bus.colour_valid},
                 {15'd0, exp_valid});
  endtask

  task automatic check_state(input string name, input logic [1:0] exp_pal,
                             input logic exp_fade);
    check_output({name, " palette"}, {14'd0, palette_idx}, {14'd0, exp_pal});
    check_output({name, " fading"}, {15'd0, fading}, {15'd0, exp_fade});
  endtask

  // Apply one pixel and check it two cycles later.
  task automatic pixel_through(input string name, input logic [2:0] q,
                               input logic [9:0] r, input logic [11:0] exp_rgb);
    apply_stimulus(1'b1, q, r);
    tick();
    tick();
    check_pixel(name, exp_rgb, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst_n         = 1'b0;
    frame_start   = 1'b0;
    pulse_trigger = 1'b0;
    apply_stimulus(1'b0, 3'd0, 10'd0);

    vecs[0]  = '{1'b1, 3'd0, 10'd100,  12'hF40};
    vecs[1]  = '{1'b1, 3'd1, 10'd100,  12'h810};
    vecs[2]  = '{1'b1, 3'd2, 10'd100,  12'hF40};
    vecs[3]  = '{1'b1, 3'd3, 10'd32,   12'h810};
    vecs[4]  = '{1'b1, 3'd4, 10'd31,   12'hFFF};
    vecs[5]  = '{1'b1, 3'd5, 10'd0,    12'hFFF};
    vecs[6]  = '{1'b1, 3'd6, 10'd100,  12'h000};
    vecs[7]  = '{1'b1, 3'd7, 10'd5,    12'h000};
    vecs[8]  = '{1'b1, 3'd7, 10'd500,  12'h000};
    vecs[9]  = '{1'b1, 3'd5, 10'd1023, 12'h810};
    vecs[10] = '{1'b0, 3'd0, 10'd100,  12'h000};

    // Reset values.
    tick();
    tick();
    check_pixel("reset", 12'h000, 1'b0);
    check_state("reset", 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Table-driven pixels in P0 HOLD; colour is don't-care when invalid.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].pv, vecs[i].q, vecs[i].r);
      tick();
      tick();
      if (vecs[i].pv) begin
        check_pixel($sformatf("vec%0d", i), vecs[i].rgb, 1'b1);
      end else begin
        check_output($sformatf("vec%0d valid", i), {15'd0, bus.colour_valid},
                     16'd0);
      end
    end
    check_state("p0 hold", 2'd0, 1'b0);

    // Back-to-back pixels, one per clock.
    apply_stimulus(1'b1, 3'd0, 10'd100);
    tick();
    apply_stimulus(1'b1, 3'd1, 10'd100);
    tick();
    check_pixel("b2b q0", 12'hF40, 1'b1);
    apply_stimulus(1'b1, 3'd2, 10'd100);
    tick();
    check_pixel("b2b q1", 12'h810, 1'b1);
    apply_stimulus(1'b0, 3'd2, 10'd100);
    tick();
    check_pixel("b2b q2", 12'hF40, 1'b1);
    tick();
    check_output("b2b tail valid", {15'd0, bus.colour_valid}, 16'd0);

`ifndef HEX_PULSE_EN
    // Without the option the beat pulse must not touch the colour.
    pulse_trigger = 1'b1;
    tick();
    pulse_trigger = 1'b0;
    pixel_through("no boost", 3'd1, 10'd100, 12'h810);
`endif

    // Fade entry after HOLD_FRAMES frames.
    apply_stimulus(1'b0, 3'd0, 10'd100);
    pulse_frames(3);
    check_state("hold 3 frames", 2'd0, 1'b0);
    pulse_frames(1);
    check_state("fade start", 2'd0, 1'b1);
    pulse_frames(8);
    pixel_through("p0 fade step8 q0", 3'd0, 10'd100, 12'h792);
    pixel_through("p0 fade step8 centre", 3'd0, 10'd10, 12'hFFF);
    pulse_frames(7);
    check_state("p0 fade step15", 2'd0, 1'b1);
    pulse_frames(1);
    check_state("p1 hold", 2'd1, 1'b0);
    pixel_through("p1 hold q0", 3'd0, 10'd100, 12'h0F4);

    // Advance to P2 and stop mid-fade at step 5.
    pulse_frames(20);
    check_state("p2 hold", 2'd2, 1'b0);
    pulse_frames(9);
    check_state("p2 fade step5", 2'd2, 1'b1);
    pixel_through("p2 fade step5 q0", 3'd0, 10'd100, 12'h42F);

    // Asynchronous reset mid-fade: outputs clear before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_pixel("async reset", 12'h000, 1'b0);
    check_state("async reset", 2'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_frames(3);
    check_state("post reset hold", 2'd0, 1'b0);
    pulse_frames(1);
    check_state("post reset fade", 2'd0, 1'b1);

    // Walk up to P3 and through the 3 -> 0 wrap.
    pulse_frames(16);
    check_state("p1 again", 2'd1, 1'b0);
    pulse_frames(20);
    check_state("p2 again", 2'd2, 1'b0);
    pulse_frames(20);
    check_state("p3 hold", 2'd3, 1'b0);
    pulse_frames(12);
    pixel_through("p3 fade step8 q0", 3'd0, 10'd100, 12'hF27);
    pulse_frames(8);
    check_state("wrap to p0", 2'd0, 1'b0);
    pixel_through("p0 after wrap", 3'd1, 10'd100, 12'h810);

`ifdef HEX_PULSE_EN
    // Boost load, decay and load-beats-decay priority.
    do_reset();
    pulse_trigger = 1'b1;
    tick();
    pulse_trigger = 1'b0;
    pixel_through("boost8 q1", 3'd1, 10'd100, 12'hC54);
    pixel_through("boost8 centre", 3'd1, 10'd10, 12'hFFF);
    pixel_through("boost8 black", 3'd6, 10'd100, 12'h000);
    pulse_frames(2);
    pixel_through("boost6 q1", 3'd1, 10'd100, 12'hB43);
    pulse_frames(2);
    pixel_through("boost4 fade0 q1", 3'd1, 10'd100, 12'hA32);
    pulse_frames(4);
    pixel_through("boost0 fade4 q1", 3'd1, 10'd100, 12'h620);
    frame_start   = 1'b1;
    pulse_trigger = 1'b1;
    tick();
    frame_start   = 1'b0;
    pulse_trigger = 1'b0;
    pixel_through("boost reload fade5 q1", 3'd1, 10'd100, 12'h974);
`endif

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
